queue_dequeue_sched: RTL and testbench

Output-side dequeue scheduler that consumes the per-queue ready vector (`queue_o_rdy`) produced by the enqueue/update stage. It picks one port/queue per transaction, requests the head descriptor from the buffer manager, and hands the returned buffer address to the selected port's transmitter. Port selection is round-robin across ports; within a port, selection is strict priority.

---
 rtl/queue_dequeue_sched_if.sv | 40 ++++
 rtl/queue_dequeue_sched.sv | 151 +++++++++++++++
 tb/tb_queue_dequeue_sched.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/queue_dequeue_sched_if.sv
// +----------------------------------------------------------------------+
// | queue_dequeue_sched_if : queue status, dequeue request, descriptor   |
// | return and transmit handoff bundle for the dequeue scheduler.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface queue_dequeue_sched_if #(
  parameter int NUM_PORTS  = 3,
  parameter int NUM_QUEUES = 8,
  parameter int ADDR_W     = 16
);
  logic [NUM_PORTS*NUM_QUEUES-1:0] queue_o_rdy;
  logic [NUM_PORTS*NUM_QUEUES-1:0] gate_open;
  logic [NUM_PORTS-1:0]            port_req;
  logic                            deq_vld_o;
  logic [1:0]                      deq_port_o;
  logic [2:0]                      deq_queue_o;
  logic                            deq_rdy_i;
  logic                            desc_vld_i;
  logic [ADDR_W-1:0]               desc_addr_i;
  logic                            tx_vld_o;
  logic [1:0]                      tx_port_o;
  logic [ADDR_W-1:0]               tx_addr_o;
  logic                            tx_rdy_i;
  logic                            err_o;
  logic                            busy_o;

  modport master (
    input  queue_o_rdy, gate_open, port_req, deq_rdy_i, desc_vld_i, desc_addr_i, tx_rdy_i,
    output deq_vld_o, deq_port_o, deq_queue_o, tx_vld_o, tx_port_o, tx_addr_o, err_o, busy_o
  );

  modport slave (
    output queue_o_rdy, gate_open, port_req, deq_rdy_i, desc_vld_i, desc_addr_i, tx_rdy_i,
    input  deq_vld_o, deq_port_o, deq_queue_o, tx_vld_o, tx_port_o, tx_addr_o, err_o, busy_o
  );
endinterface

`default_nettype wire

// File: rtl/queue_dequeue_sched.sv
// +----------------------------------------------------------------------+
// | queue_dequeue_sched : round-robin port / strict-priority queue       |
// | dequeue scheduler with descriptor timeout.                           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module queue_dequeue_sched #(
  parameter int NUM_PORTS  = 3,
  parameter int NUM_QUEUES = 8,
  parameter int ADDR_W     = 16,
  parameter int TIMEOUT    = 255
) (
  input  wire logic              clk_in,
  input  wire logic              rst,
  queue_dequeue_sched_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  state_t                         r_state, w_state_nxt;
  logic [1:0]                     r_rr_ptr;
  logic [1:0]                     r_port;
  logic [2:0]                     r_queue;
  logic [ADDR_W-1:0]              r_addr;
  logic [7:0]                     r_cnt;
  logic                           r_err;

  logic [NUM_PORTS-1:0]           w_port_elig;
  logic [NUM_PORTS-1:0][2:0]      w_port_q;
  logic                           w_any;
  logic [1:0]                     w_sel_port;
  logic [2:0]                     w_sel_q;
  logic [1:0]                     w_cand;
  logic                           w_latch;
  logic                           w_accept;
  logic                           w_desc;
  logic                           w_timeout;
  logic                           w_cnt_inc;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [NUM_QUEUES-1:0] w_qm;
    logic [2:0]            w_hi;
    assign w_qm = bus.queue_o_rdy[p*NUM_QUEUES +: NUM_QUEUES]
                & bus.gate_open[p*NUM_QUEUES +: NUM_QUEUES];
    assign w_port_elig[p] = bus.port_req[p] & (|w_qm);
    // Highest set index wins: later iterations overwrite lower ones.
    always_comb begin
      w_hi = '0;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (w_qm[q]) w_hi = 3'(q);
      end
    end
    assign w_port_q[p] = w_hi;
  end

  // Walk the search order backwards so the port nearest rr_ptr+1 wins.
  always_comb begin
    w_any      = 1'b0;
    w_sel_port = '0;
    w_sel_q    = '0;
    w_cand     = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      w_cand = 2'((32'(r_rr_ptr) + i) % NUM_PORTS);
      if (w_port_elig[w_cand]) begin
        w_any      = 1'b1;
        w_sel_port = w_cand;
        w_sel_q    = w_port_q[w_cand];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_accept    = 1'b0;
    w_desc      = 1'b0;
    w_timeout   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_state_nxt = S_REQ;
        w_latch     = 1'b1;
      end
      S_REQ: if (bus.deq_rdy_i) begin
        w_state_nxt = S_WAIT;
        w_accept    = 1'b1;
      end
      S_WAIT: begin
        if (bus.desc_vld_i) begin
          w_state_nxt = S_SEND;
          w_desc      = 1'b1;
        end else if (r_cnt == C_TMO_LAST) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      S_SEND: if (bus.tx_rdy_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_rr_ptr <= 2'd2;
      r_port   <= '0;
      r_queue  <= '0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_latch) begin
        r_port  <= w_sel_port;
        r_queue <= w_sel_q;
      end
      if (w_accept) begin
        r_rr_ptr <= r_port;
        r_cnt    <= '0;
      end
      if (w_cnt_inc) r_cnt  <= r_cnt + 8'd1;
      if (w_desc)    r_addr <= bus.desc_addr_i;
    end
  end

  assign bus.deq_vld_o   = (r_state == S_REQ);
  assign bus.deq_port_o  = r_port;
  assign bus.deq_queue_o = r_queue;
  assign bus.tx_vld_o    = (r_state == S_SEND);
  assign bus.tx_port_o   = r_port;
  assign bus.tx_addr_o   = r_addr;
  assign bus.err_o       = r_err;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_queue_dequeue_sched.sv
// +----------------------------------------------------------------------+
// | tb_queue_dequeue_sched : directed self-checking bench for the        |
// | dequeue scheduler.                                                   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_queue_dequeue_sched;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  queue_dequeue_sched_if #(.NUM_PORTS(3), .NUM_QUEUES(8), .ADDR_W(16)) bus ();

  queue_dequeue_sched #(
    .NUM_PORTS (3),
    .NUM_QUEUES(8),
    .ADDR_W    (16),
    .TIMEOUT   (4)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic zero_inputs();
    bus.queue_o_rdy = '0;
    bus.gate_open   = '0;
    bus.port_req    = '0;
    bus.deq_rdy_i   = 1'b0;
    bus.desc_vld_i  = 1'b0;
    bus.desc_addr_i = '0;
    bus.tx_rdy_i    = 1'b0;
  endtask

  task automatic apply_reset();
    zero_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.queue_o_rdy = '1;
    bus.gate_open   = '1;
    bus.port_req    = '1;
    bus.deq_rdy_i   = 1'b1;
    bus.desc_vld_i  = 1'b1;
    bus.desc_addr_i = '1;
    bus.tx_rdy_i    = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.deq_vld_o !== 1'b0)   begin errors++; $display("FAIL rst_deq_vld: got %0h expected 0", bus.deq_vld_o); end
    checks++; if (bus.tx_vld_o !== 1'b0)    begin errors++; $display("FAIL rst_tx_vld: got %0h expected 0", bus.tx_vld_o); end
    checks++; if (bus.err_o !== 1'b0)       begin errors++; $display("FAIL rst_err: got %0h expected 0", bus.err_o); end
    checks++; if (bus.busy_o !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %0h expected 0", bus.busy_o); end
    checks++; if (bus.deq_port_o !== 2'd0)  begin errors++; $display("FAIL rst_deq_port: got %0h expected 0", bus.deq_port_o); end
    checks++; if (bus.deq_queue_o !== 3'd0) begin errors++; $display("FAIL rst_deq_queue: got %0h expected 0", bus.deq_queue_o); end
    checks++; if (bus.tx_port_o !== 2'd0)   begin errors++; $display("FAIL rst_tx_port: got %0h expected 0", bus.tx_port_o); end
    checks++; if (bus.tx_addr_o !== 16'd0)  begin errors++; $display("FAIL rst_tx_addr: got %0h expected 0", bus.tx_addr_o); end
    rst = 1'b0;
    tick();
    checks++; if (bus.deq_vld_o !== 1'b1)   begin errors++; $display("FAIL first_deq_vld: got %0h expected 1", bus.deq_vld_o); end
    checks++; if (bus.deq_port_o !== 2'd0)  begin errors++; $display("FAIL first_deq_port: got %0h expected 0", bus.deq_port_o); end
    checks++; if (bus.deq_queue_o !== 3'd7) begin errors++; $display("FAIL first_deq_queue: got %0h expected 7", bus.deq_queue_o); end
  endtask

  task automatic test_priority();
    apply_reset();
    bus.queue_o_rdy = 24'h0000A0;
    bus.gate_open   = '1;
    bus.port_req    = 3'b001;
    tick();
    checks++; if (bus.deq_vld_o !== 1'b1)   begin errors++; $display("FAIL prio_vld: got %0h expected 1", bus.deq_vld_o); end
    checks++; if (bus.deq_queue_o !== 3'd7) begin errors++; $display("FAIL prio_q7: got %0h expected 7", bus.deq_queue_o); end
    bus.gate_open[7] = 1'b0;
    tick();
    checks++; if (bus.deq_queue_o !== 3'd7) begin errors++; $display("FAIL prio_inflight_hold: got %0h expected 7", bus.deq_queue_o); end
    apply_reset();
    bus.queue_o_rdy  = 24'h0000A0;
    bus.gate_open    = '1;
    bus.gate_open[7] = 1'b0;
    bus.port_req     = 3'b001;
    tick();
    checks++; if (bus.deq_queue_o !== 3'd5) begin errors++; $display("FAIL prio_q5: got %0h expected 5", bus.deq_queue_o); end
    checks++; if (bus.deq_port_o !== 2'd0)  begin errors++; $display("FAIL prio_port: got %0h expected 0", bus.deq_port_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_port [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [15:0] addr;
    apply_reset();
    bus.queue_o_rdy = '1;
    bus.gate_open   = '1;
    bus.port_req    = 3'b111;
    bus.deq_rdy_i   = 1'b1;
    bus.desc_vld_i  = 1'b1;
    bus.tx_rdy_i    = 1'b1;
    for (int n = 0; n < 4; n++) begin
      addr = 16'h1000 + 16'(n);
      bus.desc_addr_i = addr;
      tick();
      checks++; if (bus.deq_vld_o !== 1'b1 || bus.deq_port_o !== exp_port[n])
        begin errors++; $display("FAIL rr_req[%0d]: got vld=%0h port=%0h expected vld=1 port=%0h", n, bus.deq_vld_o, bus.deq_port_o, exp_port[n]); end
      tick();
      checks++; if (bus.deq_vld_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.tx_vld_o !== 1'b0)
        begin errors++; $display("FAIL rr_wait[%0d]: got deq_vld=%0h busy=%0h tx_vld=%0h expected 0 1 0", n, bus.deq_vld_o, bus.busy_o, bus.tx_vld_o); end
      tick();
      checks++; if (bus.tx_vld_o !== 1'b1 || bus.tx_port_o !== exp_port[n] || bus.tx_addr_o !== addr)
        begin errors++; $display("FAIL rr_send[%0d]: got vld=%0h port=%0h addr=%0h expected 1 %0h %0h", n, bus.tx_vld_o, bus.tx_port_o, bus.tx_addr_o, exp_port[n], addr); end
      tick();
      checks++; if (bus.busy_o !== 1'b0 || bus.tx_vld_o !== 1'b0)
        begin errors++; $display("FAIL rr_idle[%0d]: got busy=%0h tx_vld=%0h expected 0 0", n, bus.busy_o, bus.tx_vld_o); end
    end
  endtask

  task automatic test_stall_hold();
    apply_reset();
    bus.queue_o_rdy = 24'h004008;
    bus.gate_open   = '1;
    bus.port_req    = 3'b011;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.deq_vld_o !== 1'b1 || bus.deq_port_o !== 2'd0 || bus.deq_queue_o !== 3'd3)
        begin errors++; $display("FAIL stall_req[%0d]: got vld=%0h port=%0h q=%0h expected 1 0 3", c, bus.deq_vld_o, bus.deq_port_o, bus.deq_queue_o); end
      bus.queue_o_rdy = ~bus.queue_o_rdy;
      if (c < 4) tick();
    end
    bus.deq_rdy_i = 1'b1;
    tick();
    bus.deq_rdy_i = 1'b0;
    checks++; if (bus.deq_vld_o !== 1'b0) begin errors++; $display("FAIL stall_deq_drop: got %0h expected 0", bus.deq_vld_o); end
    bus.desc_vld_i  = 1'b1;
    bus.desc_addr_i = 16'hBEEF;
    tick();
    bus.desc_vld_i  = 1'b0;
    bus.desc_addr_i = 16'h0000;
    bus.queue_o_rdy = '0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.tx_vld_o !== 1'b1 || bus.tx_port_o !== 2'd0 || bus.tx_addr_o !== 16'hBEEF)
        begin errors++; $display("FAIL stall_tx[%0d]: got vld=%0h port=%0h addr=%0h expected 1 0 beef", c, bus.tx_vld_o, bus.tx_port_o, bus.tx_addr_o); end
      if (c < 2) tick();
    end
    bus.tx_rdy_i = 1'b1;
    tick();
    bus.tx_rdy_i = 1'b0;
    checks++; if (bus.tx_vld_o !== 1'b0 || bus.busy_o !== 1'b0)
      begin errors++; $display("FAIL stall_tx_drop: got vld=%0h busy=%0h expected 0 0", bus.tx_vld_o, bus.busy_o); end
  endtask

  task automatic test_timeout();
    apply_reset();
    bus.queue_o_rdy = '1;
    bus.gate_open   = '1;
    bus.port_req    = 3'b111;
    bus.deq_rdy_i   = 1'b1;
    tick();
    checks++; if (bus.deq_port_o !== 2'd0) begin errors++; $display("FAIL tmo_first_port: got %0h expected 0", bus.deq_port_o); end
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.tx_vld_o !== 1'b0)
        begin errors++; $display("FAIL tmo_wait[%0d]: got err=%0h busy=%0h tx_vld=%0h expected 0 1 0", c, bus.err_o, bus.busy_o, bus.tx_vld_o); end
      tick();
    end
    checks++; if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b0)
      begin errors++; $display("FAIL tmo_pulse: got err=%0h busy=%0h expected 1 0", bus.err_o, bus.busy_o); end
    tick();
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %0h expected 0", bus.err_o); end
    checks++; if (bus.deq_vld_o !== 1'b1 || bus.deq_port_o !== 2'd1)
      begin errors++; $display("FAIL tmo_next_port: got vld=%0h port=%0h expected 1 1", bus.deq_vld_o, bus.deq_port_o); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.queue_o_rdy = '1;
    bus.gate_open   = '1;
    bus.port_req    = 3'b111;
    bus.deq_rdy_i   = 1'b1;
    tick();
    tick();
    bus.deq_rdy_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b1 || bus.deq_vld_o !== 1'b0)
      begin errors++; $display("FAIL mrst_in_wait: got busy=%0h deq_vld=%0h expected 1 0", bus.busy_o, bus.deq_vld_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0 || bus.deq_vld_o !== 1'b0)
      begin errors++; $display("FAIL mrst_abort: got busy=%0h err=%0h deq_vld=%0h expected 0 0 0", bus.busy_o, bus.err_o, bus.deq_vld_o); end
    tick();
    checks++; if (bus.deq_vld_o !== 1'b1 || bus.deq_port_o !== 2'd0)
      begin errors++; $display("FAIL mrst_next_port: got vld=%0h port=%0h expected 1 0", bus.deq_vld_o, bus.deq_port_o); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL mrst_no_err[%0d]: got %0h expected 0", c, bus.err_o); end
    end
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_priority();
    test_round_robin();
    test_stall_hold();
    test_timeout();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
